// File: rtl/loader_pkg.sv
// Shared types and widths for the program loader.
// The FSM state enum lives here so the loader and its bench agree on names.
package loader_pkg;

    localparam int ADDR_W = 32;
    localparam int WORD_W = 32;
    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        DONE,
        ERROR
    } state_t;

endpackage

// File: rtl/byte_assembler.sv
// Collects accepted stream bytes into little-endian 32-bit words.
// The completed word and its strobe are combinational on the 4th accepted byte.
module byte_assembler
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              accept,
    input  logic [BYTE_W-1:0] in_byte,
    output logic [WORD_W-1:0] word,
    output logic              word_done
);

    logic [WORD_W-BYTE_W-1:0] shift;
    logic [1:0]               byte_index;

    // Only the three earlier bytes need storing; the 4th comes straight from the input.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift      <= '0;
            byte_index <= 2'd0;
        end else if (clear) begin
            shift      <= '0;
            byte_index <= 2'd0;
        end else if (accept) begin
            shift      <= {in_byte, shift[WORD_W-BYTE_W-1:BYTE_W]};
            byte_index <= byte_index + 2'd1;
        end
    end

    assign word      = {in_byte, shift};
    assign word_done = accept && (byte_index == 2'd3);

endmodule

// File: rtl/program_loader.sv
// Streams a length-prefixed program into instruction memory while holding the cpu in reset.
// Releases the cpu once every word has been written; oversize programs park in ERROR.
module program_loader
    import loader_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_0000,
    parameter int                MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] write_address,
    output logic [WORD_W-1:0] write_data,
    output logic              write_enable,
    output logic              cpu_reset_n,
    output logic              load_done,
    output logic              load_error,
    output logic [15:0]       words_loaded
);

    state_t            state;
    logic [WORD_W-1:0] length;
    logic [WORD_W-1:0] word;
    logic              word_done;
    logic              accept;
    logic              clear;
    logic              last_word;

    assign accept    = in_valid && in_ready;
    assign clear     = start && (state == IDLE || state == DONE || state == ERROR);
    assign last_word = ({16'd0, words_loaded} + 32'd1) == length;

    byte_assembler u_assembler (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear),
        .accept    (accept),
        .in_byte   (in_data),
        .word      (word),
        .word_done (word_done)
    );

    // All outputs are registered alongside the state so they change on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            length        <= '0;
            in_ready      <= 1'b0;
            write_enable  <= 1'b0;
            write_address <= BASE_ADDR;
            write_data    <= '0;
            cpu_reset_n   <= 1'b0;
            load_done     <= 1'b0;
            load_error    <= 1'b0;
            words_loaded  <= 16'd0;
        end else begin
            write_enable <= 1'b0;
            case (state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        state        <= LEN;
                        in_ready     <= 1'b1;
                        cpu_reset_n  <= 1'b0;
                        load_done    <= 1'b0;
                        load_error   <= 1'b0;
                        words_loaded <= 16'd0;
                    end
                end
                LEN: begin
                    if (word_done) begin
                        length <= word;
                        if (word == '0) begin
                            state       <= DONE;
                            in_ready    <= 1'b0;
                            load_done   <= 1'b1;
                            cpu_reset_n <= 1'b1;
                        end else if (word > 32'(MAX_WORDS)) begin
                            state      <= ERROR;
                            in_ready   <= 1'b0;
                            load_error <= 1'b1;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (word_done) begin
                        write_enable  <= 1'b1;
                        write_data    <= word;
                        write_address <= BASE_ADDR + {14'd0, words_loaded, 2'b00};
                        words_loaded  <= words_loaded + 16'd1;
                        // The final write and the cpu release land on the same edge.
                        if (last_word) begin
                            state       <= DONE;
                            in_ready    <= 1'b0;
                            load_done   <= 1'b1;
                            cpu_reset_n <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Randomized self-checking bench for program_loader against a queue-based write model.
module tb_program_loader;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          MAXW = 1024;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic [31:0] write_address;
    logic [31:0] write_data;
    logic        write_enable;
    logic        cpu_reset_n;
    logic        load_done;
    logic        load_error;
    logic [15:0] words_loaded;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         exp_item;
    int          model_count = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] last_addr = BASE;
    logic [31:0] last_data = 32'h0;
    logic        prev_we = 1'b0;

    program_loader #(
        .BASE_ADDR (BASE),
        .MAX_WORDS (MAXW)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .write_address (write_address),
        .write_data    (write_data),
        .write_enable  (write_enable),
        .cpu_reset_n   (cpu_reset_n),
        .load_done     (load_done),
        .load_error    (load_error),
        .words_loaded  (words_loaded)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    // Every cycle: pop the model's next write on each strobe, otherwise require stable outputs.
    always @(negedge clk) begin
        if (!reset_n) begin
            last_addr = BASE;
            last_data = 32'h0;
            prev_we   = 1'b0;
        end else begin
            if (write_enable) begin
                check_output("we_single_cycle", 32'(prev_we), 32'h0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_write: got addr 0x%08h data 0x%08h, required no write",
                             write_address, write_data);
                end else begin
                    exp_item = exp_q.pop_front();
                    check_output("write_address", write_address, exp_item.addr);
                    check_output("write_data", write_data, exp_item.data);
                    model_count++;
                end
                last_addr = write_address;
                last_data = write_data;
            end else begin
                check_output("addr_hold", write_address, last_addr);
                check_output("data_hold", write_data, last_data);
                check_output("words_loaded", 32'(words_loaded), 32'(model_count));
            end
            check_output("cpu_release_only_done", 32'(cpu_reset_n), 32'(load_done));
            check_output("done_error_exclusive", 32'(load_done & load_error), 32'h0);
            check_output("ready_only_loading", 32'(in_ready & (load_done | load_error)), 32'h0);
            prev_we = write_enable;
        end
    end

    task automatic check_reset_values();
        check_output("rst_in_ready", 32'(in_ready), 32'h0);
        check_output("rst_write_enable", 32'(write_enable), 32'h0);
        check_output("rst_write_address", write_address, BASE);
        check_output("rst_write_data", write_data, 32'h0);
        check_output("rst_cpu_reset_n", 32'(cpu_reset_n), 32'h0);
        check_output("rst_load_done", 32'(load_done), 32'h0);
        check_output("rst_load_error", 32'(load_error), 32'h0);
        check_output("rst_words_loaded", 32'(words_loaded), 32'h0);
    endtask

    task automatic pulse_start(input bit new_load);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (new_load) model_count = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b0;
        repeat (gap) begin
            in_data = 8'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL byte_accept_timeout: got in_ready 0 for 20 cycles, required 1");
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 0; i < 4; i++)
            send_byte(w[8*i +: 8], (gap < 0) ? int'($urandom_range(2, 0)) : gap);
    endtask

    // One complete load: start, length, words; the model expects BASE + 4k for word k.
    task automatic apply_stimulus(input int n, input int gap, input bit poke_start);
        logic [31:0] w;
        pulse_start(1'b1);
        check_output("start_cpu_reset_low", 32'(cpu_reset_n), 32'h0);
        check_output("start_words_cleared", 32'(words_loaded), 32'h0);
        check_output("start_done_cleared", 32'(load_done), 32'h0);
        check_output("start_in_ready", 32'(in_ready), 32'h1);
        send_word(32'(n), gap);
        for (int k = 0; k < n; k++) begin
            w = $urandom;
            exp_q.push_back('{BASE + 32'(4 * k), w});
            send_word(w, gap);
            if (poke_start && k == 0 && n > 1) pulse_start(1'b0);
        end
        repeat (2) @(posedge clk);
        #1;
        check_output("final_load_done", 32'(load_done), 32'h1);
        check_output("final_cpu_reset_n", 32'(cpu_reset_n), 32'h1);
        check_output("final_words_loaded", 32'(words_loaded), 32'(n));
        check_output("final_in_ready", 32'(in_ready), 32'h0);
        check_output("final_queue_empty", 32'(exp_q.size()), 32'h0);
    endtask

    task automatic finish_bench();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    endtask

    initial begin
        #500000;
        n_checks++;
        n_fail++;
        $display("[TB] FAIL watchdog: got no completion by 500000ns, required completion");
        finish_bench();
    end

    initial begin
        logic [7:0] basic_bytes [12];
        basic_bytes = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                        8'h93, 8'h00, 8'h10, 8'h00};

        #12;
        check_reset_values();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_output("idle_in_ready", 32'(in_ready), 32'h0);

        $display("[TB] basic two-word load");
        pulse_start(1'b1);
        exp_q.push_back('{32'h0000_0000, 32'h0000_0013});
        exp_q.push_back('{32'h0000_0004, 32'h0010_0093});
        for (int i = 0; i < 12; i++) send_byte(basic_bytes[i], 0);
        repeat (2) @(posedge clk);
        #1;
        check_output("basic_load_done", 32'(load_done), 32'h1);
        check_output("basic_cpu_reset_n", 32'(cpu_reset_n), 32'h1);
        check_output("basic_words_loaded", 32'(words_loaded), 32'h2);
        check_output("basic_queue_empty", 32'(exp_q.size()), 32'h0);

        $display("[TB] reload from DONE");
        apply_stimulus(3, 0, 1'b0);

        $display("[TB] empty program");
        pulse_start(1'b1);
        for (int i = 0; i < 3; i++) send_byte(8'h00, 0);
        in_valid = 1'b1;
        in_data  = 8'h00;
        @(negedge clk);
        check_output("empty_not_early", 32'(load_done), 32'h0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_output("empty_done", 32'(load_done), 32'h1);
        check_output("empty_cpu_reset_n", 32'(cpu_reset_n), 32'h1);
        check_output("empty_no_write", 32'(write_enable), 32'h0);
        check_output("empty_words", 32'(words_loaded), 32'h0);

        $display("[TB] length limit");
        pulse_start(1'b1);
        send_byte(8'h01, 0);
        send_byte(8'h04, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        check_output("limit_load_error", 32'(load_error), 32'h1);
        check_output("limit_cpu_reset_n", 32'(cpu_reset_n), 32'h0);
        check_output("limit_in_ready", 32'(in_ready), 32'h0);
        in_valid = 1'b1;
        repeat (8) begin
            in_data = 8'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check_output("limit_stays_error", 32'(load_error), 32'h1);
        check_output("limit_no_words", 32'(words_loaded), 32'h0);

        $display("[TB] stream gaps");
        apply_stimulus(1, 3, 1'b0);

        $display("[TB] randomized loads");
        for (int r = 0; r < 8; r++)
            apply_stimulus(int'($urandom_range(6, 1)), -1, 1'($urandom_range(1, 0)));

        $display("[TB] reset mid-load");
        pulse_start(1'b1);
        send_word(32'd2, 0);
        exp_q.push_back('{BASE, 32'hCAFE_F00D});
        send_word(32'hCAFE_F00D, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_values();
        exp_q.delete();
        model_count = 0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_output("post_reset_no_write", 32'(write_enable), 32'h0);
        apply_stimulus(2, -1, 1'b0);

        $display("[TB] maximum-length program");
        apply_stimulus(MAXW, 0, 1'b0);

        finish_bench();
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000; byte address of the first loaded word.
REQ-002 SHALL have parameter MAX_WORDS, default 1024; largest accepted program length in words.
REQ-003 SHALL have port clk, input, 1, single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, single-cycle request to (re)load a program.
REQ-006 SHALL have port in_valid, input, 1, stream byte valid.
REQ-007 SHALL have port in_data, input, 8, stream byte.
REQ-008 SHALL have port in_ready, output, 1, loader accepts a byte this cycle.
REQ-009 SHALL have port write_address, output, 32, instruction memory byte address, driven to cpu write_address.
REQ-010 SHALL have port write_data, output, 32, assembled instruction word, driven to cpu write_data.
REQ-011 SHALL have port write_enable, output, 1, one-cycle memory write strobe, driven to cpu write_enable.
REQ-012 SHALL have port cpu_reset_n, output, 1, holds the cpu in reset while low.
REQ-013 SHALL have port load_done, output, 1, high in DONE.
REQ-014 SHALL have port load_error, output, 1, high in ERROR.
REQ-015 SHALL have port words_loaded, output, 16, number of words written in the current load.

Function
REQ-016 SHALL implement the FSM states IDLE, LEN, DATA, DONE and ERROR.
REQ-017 SHALL transition IDLE->LEN on start.
REQ-018 SHALL, in LEN and DATA, drive in_ready=1; in all other states in_ready=0.
REQ-019 SHALL accept a byte only when in_valid && in_ready.
REQ-020 SHALL, in LEN, assemble 4 accepted bytes little-endian (first byte = bits 7:0) into a 32-bit length N.
REQ-021 SHALL, after the 4th length byte, go to DONE if N==0, to ERROR if N>MAX_WORDS, and otherwise to DATA.
REQ-022 SHALL, in DATA, assemble each group of 4 accepted bytes little-endian into write_data.
REQ-023 SHALL, on the cycle after the 4th byte of word k (k from 0) is accepted, pulse write_enable for exactly one cycle with write_address = BASE_ADDR + 4*k.
REQ-024 SHALL hold write_address and write_data stable outside write_enable pulses.
REQ-025 SHALL increment words_loaded on each write_enable pulse.
REQ-026 SHALL go DATA->DONE in the same cycle that the write_enable pulse for word N-1 is issued.
REQ-027 SHALL not stall on stream gaps; in_valid=0 keeps the partial byte index and word count unchanged.
REQ-028 SHALL drive cpu_reset_n low in IDLE, LEN, DATA and ERROR, and high only in DONE (registered).
REQ-029 SHALL, on start in DONE or ERROR, clear words_loaded and the byte index, lower cpu_reset_n on the next cycle, and enter LEN.
REQ-030 SHALL ignore start while in LEN or DATA.
REQ-031 SHALL remain in ERROR, issuing no writes, until the next start.

Reset
REQ-032 SHALL, on reset_n low and regardless of clk, force state=IDLE, in_ready=0, write_enable=0, write_address=BASE_ADDR, write_data=0, cpu_reset_n=0, load_done=0, load_error=0, words_loaded=0, byte index=0.
REQ-033 SHALL, on reset mid-load, abandon the partial word with no further write_enable pulse.
REQ-034 SHALL make its first state change no earlier than the first rising clk edge after reset_n deasserts.

Structure
REQ-035 SHALL take the FSM state enum and the 32-bit address/word widths from a shared package, loader_pkg.
REQ-036 SHALL implement the byte-to-word assembler (byte index, shift register, word-complete strobe) as sub-module byte_assembler, used for both the LEN and DATA phases.

Verification
REQ-037 SHALL verify the basic load: start, then bytes 02 00 00 00 13 00 00 00 93 00 10 00 -> writes (0x0, 0x00000013) and (0x4, 0x00100093); then load_done=1, cpu_reset_n=1, words_loaded=2.
REQ-038 SHALL verify an empty program: length 00 00 00 00 -> no write_enable; DONE on the cycle after the 4th byte.
REQ-039 SHALL verify the length limit: length 0x401 with MAX_WORDS=1024 -> load_error=1, cpu_reset_n=0, no writes, in_ready=0.
REQ-040 SHALL verify stream gaps: one-word load with in_valid low 3 cycles between every byte -> single correct write, words_loaded=1.
REQ-041 SHALL verify reset mid-load: reset_n low after 2 bytes of word 1 -> all outputs at reset values; a fresh start plus a full stream loads from BASE_ADDR.
REQ-042 SHALL verify reload: start in DONE -> cpu_reset_n low on the next cycle, words_loaded=0, and the second program is written from BASE_ADDR.
